nn_layer_engine: RTL and testbench

//  Parametrised successor to the fixed 4-unit network datapath. Holds NUM_UNITS activations,

---
 rtl/nn_layer_engine.sv | 199 +++++++++++++++++++
 tb/tb_nn_layer_engine.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_engine.sv
// Multi-layer fully-connected engine: NUM_UNITS parallel MACs fed by a synchronous weight RAM,
// with ReLU-and-saturate activation between layers and a one-cycle done pulse per run.
module nn_layer_engine #(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned NUM_LAYERS = 2,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WEIGHT_W   = 8,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned FRAC_BITS  = 4,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          w_rd_en,
    output logic [ADDR_W-1:0]             w_addr,
    input  logic [NUM_UNITS*WEIGHT_W-1:0] w_data,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_UNITS*DATA_W-1:0]   out_data,
    output logic                          rez
);

    localparam int unsigned IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned LAYER_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned PROD_W   = DATA_W + WEIGHT_W + 1;
    localparam int unsigned MIN_ACC_W = DATA_W + WEIGHT_W + $clog2(NUM_UNITS) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StMac,
        StAct,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    logic [LAYER_W-1:0]          layer_q, layer_d;
    logic [DATA_W-1:0]           act_q [NUM_UNITS];
    logic [DATA_W-1:0]           act_d [NUM_UNITS];
    logic [DATA_W-1:0]           act_relu [NUM_UNITS];
    logic signed [ACC_W-1:0]     acc_q [NUM_UNITS];
    logic signed [ACC_W-1:0]     acc_d [NUM_UNITS];
    logic signed [ACC_W-1:0]     acc_mac [NUM_UNITS];
    logic [NUM_UNITS*DATA_W-1:0] out_q, out_d;
    logic                        rez_q, rez_d;

    logic [DATA_W-1:0] act_cur;
    logic              last_unit;
    logic              last_layer;
    logic [IDX_W:0]    next_k;
    logic [ADDR_W-1:0] layer_base;

    // Cycle i of MAC broadcasts act[i] to every unit.
    assign act_cur    = act_q[cnt_q];
    assign last_unit  = (cnt_q == IDX_W'(NUM_UNITS - 1));
    assign last_layer = (layer_q == LAYER_W'(NUM_LAYERS - 1));
    assign next_k     = {1'b0, cnt_q} + (IDX_W + 1)'(1);
    assign layer_base = ADDR_W'(layer_q) * ADDR_W'(NUM_UNITS);

    for (genvar j = 0; j < NUM_UNITS; j++) begin : g_unit
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] w_ext;
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  shifted;

        // Activations are unsigned, so zero-extend before the signed multiply.
        assign a_ext = $signed({{(WEIGHT_W + 1){1'b0}}, act_cur});
        assign w_ext = $signed({{(DATA_W + 1){w_data[j*WEIGHT_W + WEIGHT_W - 1]}},
                                w_data[j*WEIGHT_W +: WEIGHT_W]});
        assign prod  = a_ext * w_ext;
        assign acc_mac[j] = acc_q[j] + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

        assign shifted     = acc_q[j] >>> FRAC_BITS;
        assign act_relu[j] = shifted[ACC_W-1]             ? '0 :
                             (|shifted[ACC_W-2:DATA_W])   ? '1 :
                             shifted[DATA_W-1:0];
    end

    always_comb begin
        in_ready = (state_q == StLoad);
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        w_rd_en  = 1'b0;
        w_addr   = '0;
        if (state_q == StFetch) begin
            w_rd_en = 1'b1;
            w_addr  = layer_base;
        end else if (state_q == StMac && next_k < (IDX_W + 1)'(NUM_UNITS)) begin
            w_rd_en = 1'b1;
            w_addr  = layer_base + ADDR_W'(next_k);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        layer_d = layer_q;
        act_d   = act_q;
        acc_d   = acc_q;
        out_d   = out_q;
        rez_d   = rez_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    act_d[cnt_q] = in_data;
                    if (last_unit) begin
                        state_d = StFetch;
                        cnt_d   = '0;
                        layer_d = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            StFetch: begin
                for (int j = 0; j < NUM_UNITS; j++) begin
                    acc_d[j] = '0;
                end
                cnt_d   = '0;
                state_d = StMac;
            end
            StMac: begin
                acc_d = acc_mac;
                if (last_unit) begin
                    cnt_d   = '0;
                    state_d = StAct;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            StAct: begin
                act_d = act_relu;
                if (last_layer) begin
                    state_d = StDone;
                end else begin
                    layer_d = layer_q + LAYER_W'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                rez_d = 1'b1;
                for (int j = 0; j < NUM_UNITS; j++) begin
                    out_d[j*DATA_W +: DATA_W] = act_q[j];
                    if (act_q[j] == '0) begin
                        rez_d = 1'b0;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            layer_q <= '0;
            out_q   <= '0;
            rez_q   <= 1'b0;
            for (int j = 0; j < NUM_UNITS; j++) begin
                act_q[j] <= '0;
                acc_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
            out_q   <= out_d;
            rez_q   <= rez_d;
            act_q   <= act_d;
            acc_q   <= acc_d;
        end
    end

    assign out_data = out_q;
    assign rez      = rez_q;

    // Accumulator width must cover the worst-case dot product without wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (ACC_W >= MIN_ACC_W)
            else $error("nn_layer_engine: ACC_W=%0d below required %0d", ACC_W, MIN_ACC_W);
        end
    end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Self-checking bench for nn_layer_engine: directed scenarios plus randomized runs compared
// against a plain-arithmetic model of the layer stack.
module tb_nn_layer_engine;

    localparam int N   = 4;
    localparam int L   = 2;
    localparam int DW  = 8;
    localparam int WW  = 8;
    localparam int AW  = 24;
    localparam int F   = 4;
    localparam int ADW = 10;
    localparam int LAT = L * (N + 2) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              w_rd_en;
    logic [ADW-1:0]    w_addr;
    logic [N*WW-1:0]   w_data;
    logic              busy;
    logic              done;
    logic [N*DW-1:0]   out_data;
    logic              rez;

    logic [N*WW-1:0]   mem [1024];
    int                addr_log [$];
    int                addr_bad;
    int                done_cnt;
    int                checks;
    int                failures;

    nn_layer_engine #(
        .NUM_UNITS (N),
        .NUM_LAYERS(L),
        .DATA_W    (DW),
        .WEIGHT_W  (WW),
        .ACC_W     (AW),
        .FRAC_BITS (F),
        .ADDR_W    (ADW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .w_rd_en (w_rd_en),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .busy    (busy),
        .done    (done),
        .out_data(out_data),
        .rez     (rez)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_data <= mem[w_addr];
    end

    always @(negedge clk) begin
        if (w_rd_en) addr_log.push_back(int'(w_addr));
        else if (w_addr != '0) addr_bad++;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic logic [N*DW-1:0] model(input logic [N*DW-1:0] vin);
        int a [N];
        int nxt [N];
        int acc;
        int s;
        logic [N*WW-1:0] word;
        logic signed [WW-1:0] ws;
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) a[k] = int'(vin[k*DW +: DW]);
        for (int l = 0; l < L; l++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) begin
                    word = mem[l*N + k];
                    ws   = word[j*WW +: WW];
                    acc += a[k] * int'(ws);
                end
                s      = acc >>> F;
                nxt[j] = (s < 0) ? 0 : ((s > (1 << DW) - 1) ? (1 << DW) - 1 : s);
            end
            a = nxt;
        end
        for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(a[j]);
        return r;
    endfunction

    function automatic logic all_nonzero(input logic [N*DW-1:0] v);
        logic [N*DW-1:0] t;
        t = v;
        for (int j = 0; j < N; j++) if (t[j*DW +: DW] == '0) return 1'b0;
        return 1'b1;
    endfunction

    // Weight word at layer l, input k: diag entries = scale, off-diagonal = 0.
    task automatic set_diag(input int l, input int scale);
        for (int k = 0; k < N; k++) begin
            mem[l*N + k] = '0;
            mem[l*N + k][k*WW +: WW] = WW'(scale);
        end
    endtask

    task automatic set_all(input int l, input int w);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) mem[l*N + k][j*WW +: WW] = WW'(w);
    endtask

    // Junk offered with start in IDLE must not be captured. Returns at the cycle after the last accept.
    task automatic start_and_load(input logic [N*DW-1:0] v, input bit gappy, output bit ok);
        int idx;
        int cyc;
        bit acc;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        while (idx < N && cyc < 200) begin
            in_valid = gappy ? 1'($urandom_range(1)) : 1'b1;
            in_data  = in_valid ? v[idx*DW +: DW] : DW'($urandom);
            acc      = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        ok = (idx == N);
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, w_rd_en, busy, done, rez} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {in_ready, w_rd_en, busy, done, rez});
        end
        checks++;
        if (w_addr !== '0) begin
            failures++; $display("FAIL reset_w_addr got=%h exp=0", w_addr);
        end
        checks++;
        if (out_data !== '0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Runs one vector and checks latency, output, rez, done width and return to idle.
    task automatic run_and_check(input string name, input logic [N*DW-1:0] v,
                                 input logic [N*DW-1:0] exp, input bit gappy);
        bit ok;
        int lat;
        logic exp_rez;
        exp_rez = all_nonzero(exp);
        start_and_load(v, gappy, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL %s_load got=incomplete exp=%0d beats", name, N);
        end
        wait_done(1, lat);
        checks++;
        if (lat !== LAT) begin
            failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, LAT);
        end
        @(negedge clk);
        checks++;
        if (out_data !== exp || rez !== exp_rez) begin
            failures++;
            $display("FAIL %s_out got=%h/%b exp=%h/%b", name, out_data, rez, exp, exp_rez);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_idle got done=%b busy=%b exp=0/0", name, done, busy);
        end
    endtask

    task automatic test_identity;
        set_diag(0, 16);
        set_diag(1, 16);
        run_and_check("t1_identity", {8'd9, 8'd7, 8'd5, 8'd3}, {8'd9, 8'd7, 8'd5, 8'd3}, 1'b0);
    endtask

    task automatic test_relu;
        set_all(0, -1);
        set_all(1, -1);
        run_and_check("t2_relu", {8'd40, 8'd30, 8'd20, 8'd10}, '0, 1'b0);
    endtask

    task automatic test_saturation;
        set_all(0, 127);
        set_all(1, 127);
        run_and_check("t3_sat", {N{8'd255}}, {N{8'd255}}, 1'b0);
        checks++;
        if ($isunknown(out_data)) begin
            failures++; $display("FAIL t3_no_x got=%h exp=known", out_data);
        end
    endtask

    task automatic test_two_layer;
        bit seq_ok;
        set_diag(0, 16);
        set_diag(1, 32);
        addr_log.delete();
        addr_bad = 0;
        run_and_check("t4_two_layer", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 1'b0);
        seq_ok = (addr_log.size() == L * N);
        if (seq_ok) for (int i = 0; i < L * N; i++) if (addr_log[i] != i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            failures++; $display("FAIL t4_addr_seq got=%p exp=0..%0d", addr_log, L * N - 1);
        end
        checks++;
        if (addr_bad !== 0) begin
            failures++; $display("FAIL t4_addr_idle_zero got=%0d exp=0", addr_bad);
        end
    endtask

    task automatic test_gaps_and_start;
        bit ok;
        int lat;
        set_diag(0, 16);
        set_diag(1, 16);
        run_and_check("t5_gaps", {8'd9, 8'd7, 8'd5, 8'd3}, {8'd9, 8'd7, 8'd5, 8'd3}, 1'b1);
        start_and_load({8'd9, 8'd7, 8'd5, 8'd3}, 1'b1, ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        checks++;
        if (lat !== LAT) begin
            failures++; $display("FAIL t5_start_in_mac_latency got=%0d exp=%0d", lat, LAT);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_data !== {8'd9, 8'd7, 8'd5, 8'd3}) begin
            failures++;
            $display("FAIL t5_start_ignored got busy=%b rdy=%b out=%h exp=0/0/09070503",
                     busy, in_ready, out_data);
        end
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        int snap;
        set_diag(0, 16);
        set_diag(1, 32);
        start_and_load({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, ok);
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || w_rd_en !== 1'b1 || w_addr !== ADW'(6)) begin
            failures++;
            $display("FAIL t6_in_layer1_mac got busy=%b rd=%b addr=%0d exp=1/1/6",
                     busy, w_rd_en, w_addr);
        end
        snap  = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_data !== '0 || rez !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL t6_abort got busy=%b out=%h rez=%b done=%b exp=0/0/0/0",
                     busy, out_data, rez, done);
        end
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (done_cnt !== snap || busy !== 1'b0) begin
            failures++;
            $display("FAIL t6_no_done got pulses=%0d busy=%b exp=0/0", done_cnt - snap, busy);
        end
        run_and_check("t6_rerun", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 1'b0);
    endtask

    task automatic test_random;
        logic [N*DW-1:0] v;
        logic [N*DW-1:0] exp;
        for (int r = 0; r < 24; r++) begin
            for (int a = 0; a < L * N; a++)
                for (int j = 0; j < N; j++)
                    mem[a][j*WW +: WW] = WW'(int'($urandom_range(40)) - 20);
            for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'($urandom_range(255));
            exp = model(v);
            run_and_check("rand", v, exp, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        addr_bad = 0;
        done_cnt = 0;
        w_data   = '0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_identity();
        test_relu();
        test_saturation();
        test_two_layer();
        test_gaps_and_start();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
